// File: rtl/mdu_sequencer.sv
// mdu_sequencer -- multi-cycle multiply/divide sequencer for the execute stage.
//
// Runs a 32-iteration shift-add multiply or restoring divide. It does not own
// an adder: every add/subtract step goes through the shared pipeline ALU via
// ALUCode/ALU_A/ALU_B, and the result comes back combinationally on ALUResult
// in the same cycle.
//
// Optional feature macro: MDU_SIGNED_EN
//   defined   -> op[1]=1 selects signed operation. Operands are converted to
//                magnitudes at start, and one extra FIX cycle applies the signs.
//   undefined -> op[1] is ignored, the FIX state does not exist, and all
//                operations are unsigned.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         request pulse, only looked at in IDLE
//   op[1:0]       op[0]: 0=multiply 1=divide; op[1]: signed (macro only)
//   SrcA, SrcB    multiplicand/dividend, multiplier/divisor
//   busy          high from the cycle after acceptance through the DONE cycle
//   done          one-cycle pulse; Hi/Lo are valid from then until next start
//   div_by_zero   set with done for a divide whose SrcB was 0
//   Hi, Lo        product[63:32]/remainder, product[31:0]/quotient
//   ALUCode       to shared ALU: 4'b0000 add, 4'b0001 sub
//   ALU_A, ALU_B  shared ALU operands (zero and add outside MUL/DIV)
//   ALUResult     combinational result of the shared ALU
//   o_state       debug view of the FSM state register
//
// Handshake: start is a request that is accepted on any rising edge where the
// FSM is in IDLE. There is no ready output; busy=1 means a request would be
// dropped. Acceptance is answered by exactly one done pulse (the last busy
// cycle), after which the block is back in IDLE.

module mdu_sequencer #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic [3:0]      ALUCode,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  input  logic [XLEN-1:0] ALUResult,
  output logic [2:0]      o_state
);

  localparam int              CW      = $clog2(ITER);
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
  localparam logic [3:0]      ALU_ADD = 4'b0000;
  localparam logic [3:0]      ALU_SUB = 4'b0001;

`ifdef MDU_SIGNED_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_DONE = 3'd4
  } state_t;
`endif

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;   // M for multiply, D for divide
  logic            r_dbz;

  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_carry;
  logic [XLEN-1:0] w_t;
  logic            w_sub_ok;
  state_t          w_after_last;

`ifdef MDU_SIGNED_EN
  logic r_sgn;
  logic r_sa;
  logic r_sb;
  logic r_div;

  // Signed mode works on magnitudes; the signs are reapplied in FIX.
  assign w_a_mag      = (op[1] & SrcA[XLEN-1]) ? -SrcA : SrcA;
  assign w_b_mag      = (op[1] & SrcB[XLEN-1]) ? -SrcB : SrcB;
  assign w_after_last = r_sgn ? S_FIX : S_DONE;
`else
  logic w_unused_op1;

  assign w_unused_op1 = op[1];
  assign w_a_mag      = SrcA;
  assign w_b_mag      = SrcB;
  assign w_after_last = S_DONE;
`endif

  // Multiply: the ALU sum wrapped exactly when it came out below Hi, which is
  // the carry into bit 64 of the partial product.
  assign w_carry  = (ALUResult < r_hi);

  // Divide: the partial remainder s = {Hi, Lo[31]} is 33 bits; t is its low
  // word. If s[32] is set, s is certainly >= D and the wrapped 32-bit ALU
  // difference is the correct new remainder.
  assign w_t      = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  assign w_sub_ok = r_hi[XLEN-1] | (w_t >= r_opnd);

  always_comb begin
    ALUCode = ALU_ADD;
    ALU_A   = '0;
    ALU_B   = '0;
    case (r_state)
      S_MUL: begin
        ALUCode = ALU_ADD;
        ALU_A   = r_hi;
        ALU_B   = r_opnd;
      end
      S_DIV: begin
        ALUCode = ALU_SUB;
        ALU_A   = w_t;
        ALU_B   = r_opnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_dbz   <= 1'b0;
`ifdef MDU_SIGNED_EN
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_dbz <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_sgn <= op[1];
            r_sa  <= op[1] & SrcA[XLEN-1];
            r_sb  <= op[1] & SrcB[XLEN-1];
            r_div <= op[0];
`endif
            if (op[0] && (SrcB == '0)) begin
              // Divide by zero skips iteration and FIX; dividend goes to Hi raw.
              r_hi    <= SrcA;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_opnd  <= w_b_mag;
              r_lo    <= w_a_mag;
              r_hi    <= '0;
              r_state <= op[0] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_lo[0]) {r_hi, r_lo} <= {w_carry, ALUResult, r_lo[XLEN-1:1]};
          else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[XLEN-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= w_after_last;
        end
        S_DIV: begin
          if (w_sub_ok) begin
            r_hi <= ALUResult;
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= w_t;
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= w_after_last;
        end
`ifdef MDU_SIGNED_EN
        S_FIX: begin
          // Quotient sign is sa^sb; remainder takes the dividend's sign.
          if (r_div) begin
            if (r_sa ^ r_sb) r_lo <= -r_lo;
            if (r_sa)        r_hi <= -r_hi;
          end else if (r_sa ^ r_sb) begin
            {r_hi, r_lo} <= -{r_hi, r_lo};
          end
          r_state <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dbz;
  assign Hi          = r_hi;
  assign Lo          = r_lo;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer -- bench for mdu_sequencer.
// Provides the shared ALU as a combinational add/sub, runs a table of directed
// vectors, hand-written sequences (start while busy, reset mid-operation), and
// random operations checked against a 64-bit arithmetic reference model.
// Compile with +define+MDU_SIGNED_EN to exercise the signed build.

module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [3:0]  ALUCode;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [31:0] ALUResult;
  logic [2:0]  o_state;

  int n_checks;
  int n_pass;

  mdu_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .Hi(Hi), .Lo(Lo),
    .ALUCode(ALUCode), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALUResult(ALUResult),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU of the pipeline.
  always_comb begin
    ALUResult = (ALUCode == 4'b0001) ? (ALU_A - ALU_B) : (ALU_A + ALU_B);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

`ifdef MDU_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  // Reference model: plain 64-bit arithmetic.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output logic dbz, output int lat);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    bit s;
    s   = SIGNED_BUILD && o[1];
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    dbz = 1'b0;
    lat = s ? 34 : 33;
    if (!o[0]) begin
      if (s) p = sa * sb;
      else   p = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 1;
    end else if (s) begin
      sq = sa / sb;
      sr = sa % sb;
      lo = sq[31:0];
      hi = sr[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // ---------------- driver ----------------
  // Cycle 0 is the cycle whose rising edge samples start. poke_cyc injects a
  // start during the operation; rst_cyc asserts reset during that cycle.
  task automatic run_op(input string nm, input logic [1:0] op_i,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_dbz, input int e_lat,
                        input int poke_cyc, input int rst_cyc);
    int  cyc;
    bit  aborted;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; op = op_i; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      chk({nm, ".busy"}, {31'd0, busy}, 32'd1);
      if (e_lat > 1 && cyc <= 32) chk({nm, ".alucode"}, {28'd0, ALUCode}, {31'd0, op_i[0]});
      if (cyc == 1) chk({nm, ".dbz_clr"}, {31'd0, div_by_zero}, 32'd0);
      if (cyc == poke_cyc) begin
        start = 1'b1; op = 2'b01; SrcA = 32'd1000; SrcB = 32'd3;
      end
      if (cyc == poke_cyc + 1) start = 1'b0;
      if (cyc == rst_cyc) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({nm, ".rst_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".rst_done"}, {31'd0, done}, 32'd0);
        chk({nm, ".rst_dbz"},  {31'd0, div_by_zero}, 32'd0);
        chk({nm, ".rst_hi"},   Hi, 32'd0);
        chk({nm, ".rst_lo"},   Lo, 32'd0);
        chk({nm, ".rst_code"}, {28'd0, ALUCode}, 32'd0);
        chk({nm, ".rst_a"},    ALU_A, 32'd0);
        chk({nm, ".rst_b"},    ALU_B, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      chk({nm, ".done"},    {31'd0, done}, 32'd1);
      chk({nm, ".latency"}, cyc, e_lat);
      chk({nm, ".busy_dn"}, {31'd0, busy}, 32'd1);
      chk({nm, ".hi"},      Hi, e_hi);
      chk({nm, ".lo"},      Lo, e_lo);
      chk({nm, ".dbz"},     {31'd0, div_by_zero}, {31'd0, e_dbz});
      @(negedge clk);
      chk({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
      chk({nm, ".idle_busy"},  {31'd0, busy}, 32'd0);
      chk({nm, ".idle_code"},  {28'd0, ALUCode}, 32'd0);
      @(negedge clk);
      chk({nm, ".hold_hi"}, Hi, e_hi);
      chk({nm, ".hold_lo"}, Lo, e_lo);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] m_hi, m_lo;
    logic        m_dbz;
    int          m_lat;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    n_checks = 0;
    n_pass   = 0;
    start = 1'b0; op = 2'b00; SrcA = '0; SrcB = '0;

    rst_n = 1'b0;
    #12;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.dbz",  {31'd0, div_by_zero}, 32'd0);
    chk("reset.hi",   Hi, 32'd0);
    chk("reset.lo",   Lo, 32'd0);
    chk("reset.code", {28'd0, ALUCode}, 32'd0);
    chk("reset.a",    ALU_A, 32'd0);
    chk("reset.b",    ALU_B, 32'd0);
    rst_n = 1'b1;

    vecs[0] = '{2'b00, 32'd7,         32'd6,         32'd0,         32'd42,        1'b0, 33};
    vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[2] = '{2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         1'b0, 33};
    vecs[4] = '{2'b01, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[5] = '{2'b00, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0, 33};
    vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};
`ifdef MDU_SIGNED_EN
    vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[9] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34};
`else
    vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'd3,         32'd2,         32'hFFFF_FFEB, 1'b0, 33};
    vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 1'b0, 33};
    vecs[9] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 33};
`endif

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat, -1, -1);
    end

    // start pulse in cycle 10 of a multiply is ignored
    run_op("poke", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 10, -1);

    // reset in cycle 15 aborts, then a fresh operation completes normally
    run_op("midrst", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, -1, 15);
    run_op("postrst", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1, -1);

    // random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 15));
      ref_model(r_op, r_a, r_b, m_hi, m_lo, m_dbz, m_lat);
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, m_hi, m_lo, m_dbz, m_lat, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
